dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle MIPS core and one external requester (debug/DMA loader) using a valid/ready handshake.
- Sits between the core's memory outputs (mem_write, alu_out, write_data, read_data) and the data memory.
- The CPU has fixed priority. A starvation counter guarantees the external port is served within a bounded number of cycles; the CPU is stalled for those cycles.

Parameters:
- DATA_WIDTH, 32, width of data and address buses.
- MAX_WAIT, 4, number of consecutive blocked external cycles before the external requester is forced through. Legal range 1..255.
- CNT_WIDTH, 8, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  core performs a memory access this cycle (load or store).
- cpu_we  in  1  core store enable (the core's mem_write).
- cpu_addr  in  DATA_WIDTH  core byte address (alu_out).
- cpu_wdata  in  DATA_WIDTH  core store data.
- cpu_rdata  out  DATA_WIDTH  load data returned to core.
- cpu_stall  out  1  core must hold its PC/state this cycle.
- ext_valid  in  1  external request pending.
- ext_we  in  1  external write (1) / read (0).
- ext_addr  in  DATA_WIDTH  external byte address.
- ext_wdata  in  DATA_WIDTH  external write data.
- ext_ready  out  1  external request accepted this cycle when ext_valid=1.
- ext_rdata  out  DATA_WIDTH  registered external read data.
- ext_rvalid  out  1  one-cycle pulse: ext_rdata is valid.
- mem_we  out  1  to data memory write_enable.
- mem_addr  out  DATA_WIDTH  to data memory address.
- mem_wdata  out  DATA_WIDTH  to data memory write_data.
- mem_rdata  in  DATA_WIDTH  from data memory read_data (combinational read).

Behaviour:
- Reset (reset=1 at a clock edge): wait_cnt=0, ext_rdata=0, ext_rvalid=0. Stats counters, if present, also clear to 0.
- While reset is held, combinational outputs still follow the rules below. Any transaction in flight when reset asserts is dropped: no rvalid is issued.
- ext_ready = !cpu_req || (wait_cnt == MAX_WAIT). ext_ready is combinational and does not depend on ext_valid.
- ext_grant = ext_valid && ext_ready.
- When ext_grant=1, the memory port is driven by the external requester:
  - mem_we = ext_we
  - mem_addr = ext_addr
  - mem_wdata = ext_wdata
- When ext_grant=0, the memory port is driven by the CPU:
  - mem_we = cpu_req && cpu_we
  - mem_addr = cpu_addr
  - mem_wdata = cpu_wdata
- cpu_stall = cpu_req && ext_grant. This can only be 1 on a forced (starvation) grant.
- cpu_rdata = mem_rdata, combinational. Its value is don't-care while cpu_stall=1.
- wait_cnt update, evaluated each edge:
  - If ext_grant or !ext_valid: 0.
  - Else if wait_cnt < MAX_WAIT: wait_cnt+1.
  - Else: hold.
- Guarantee: a held ext_valid is accepted no later than MAX_WAIT+1 cycles after it first asserts.
- External reads: on a cycle with ext_grant && !ext_we, at the edge ext_rdata <= mem_rdata and ext_rvalid <= 1. On every other edge ext_rvalid <= 0 and ext_rdata holds its value.
  - Read latency is 1 cycle after acceptance.
  - Back-to-back accepted reads give back-to-back rvalid pulses.
- External writes: committed by the memory at the accepting edge. No response is generated.
- Simultaneous CPU store and forced external write: only the external write reaches memory. The core is stalled and re-presents its store next cycle.
- Address and data pass through unmodified; alignment is the memory's responsibility.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds three outputs:
  - stat_ext_grants (32): count of ext_grant cycles.
  - stat_cpu_stalls (32): count of cpu_stall cycles.
  - stat_max_wait (CNT_WIDTH): the highest wait_cnt value reached.
- All three clear on reset. The 32-bit counters wrap modulo 2^32; stat_max_wait saturates.
- When undefined, these ports and their registers do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Idle CPU, ext read at addr 0x10 holding 0xDEADBEEF -> ext_ready=1 the same cycle; next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF; cpu_stall stays 0.
- cpu_req=1 on every cycle, ext_valid held from cycle 0, MAX_WAIT=4 -> ext_ready=0 for cycles 0-3; in cycle 4 ext_ready=1, cpu_stall=1, mem_addr=ext_addr; wait_cnt returns to 0.
- CPU store 0x55 to addr 0x20 while ext_valid=0 -> mem_we=1, mem_addr=0x20, mem_wdata=0x55; ext_ready=1; no stall.
- Forced ext write 0xAA to addr 0x20 colliding with CPU store 0x55 to addr 0x20 -> memory holds 0xAA after cycle N; CPU re-presents the store in cycle N+1 and memory holds 0x55 afterwards.
- ext_valid drops after 2 blocked cycles, then reasserts -> wait_cnt restarts from 0; the forced grant arrives MAX_WAIT cycles after the reassertion.
- Reset asserted in the cycle of an accepted ext read -> ext_rvalid=0 on the following cycle, ext_rdata=0, wait_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Signal bundle for the data-memory arbiter: core request, external requester and memory port.
// master = the side driving requests and the memory read data; slave = the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  ext_valid;
  logic                  ext_we;
  logic [DATA_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic                  ext_ready;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_rvalid;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata,
    input  ext_ready, ext_rdata, ext_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata,
    output ext_ready, ext_rdata, ext_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, a starvation counter forces the external
// requester through after MAX_WAIT blocked cycles. Define DMEM_ARB_STATS_EN for statistics outputs.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]          stat_ext_grants,
  output logic [31:0]          stat_cpu_stalls,
  output logic [CNT_WIDTH-1:0] stat_max_wait
`endif
);

  localparam logic [CNT_WIDTH-1:0] MaxWait = CNT_WIDTH'(MAX_WAIT);

  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [CNT_WIDTH-1:0]  wait_cnt_next;
  logic                  ext_grant;
  logic [DATA_WIDTH-1:0] ext_rdata_q;
  logic                  ext_rvalid_q;

  always_comb begin
    bus.ext_ready = !bus.cpu_req || (wait_cnt == MaxWait);
    ext_grant     = bus.ext_valid && bus.ext_ready;

    if (ext_grant) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end else begin
      bus.mem_we    = bus.cpu_req && bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end

    // Only a forced grant can coincide with an active CPU request.
    bus.cpu_stall = bus.cpu_req && ext_grant;
    bus.cpu_rdata = bus.mem_rdata;

    if (ext_grant || !bus.ext_valid) begin
      wait_cnt_next = '0;
    end else if (wait_cnt < MaxWait) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end else begin
      wait_cnt_next = wait_cnt;
    end

    bus.ext_rdata  = ext_rdata_q;
    bus.ext_rvalid = ext_rvalid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      wait_cnt     <= wait_cnt_next;
      ext_rvalid_q <= ext_grant && !bus.ext_we;
      if (ext_grant && !bus.ext_we) begin
        ext_rdata_q <= bus.mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0]          grants_q;
  logic [31:0]          stalls_q;
  logic [CNT_WIDTH-1:0] max_wait_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grants_q   <= '0;
      stalls_q   <= '0;
      max_wait_q <= '0;
    end else begin
      if (ext_grant) begin
        grants_q <= grants_q + 32'd1;
      end
      if (bus.cpu_stall) begin
        stalls_q <= stalls_q + 32'd1;
      end
      // wait_cnt never exceeds MAX_WAIT, so tracking the peak saturates by construction.
      if (wait_cnt_next > max_wait_q) begin
        max_wait_q <= wait_cnt_next;
      end
    end
  end

  assign stat_ext_grants = grants_q;
  assign stat_cpu_stalls = stalls_q;
  assign stat_max_wait   = max_wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle reference model of arbitration plus a
// scoreboard queue of expected external read data.
module tb_dmem_arbiter;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_ext_grants;
  logic [31:0] stat_cpu_stalls;
  logic [7:0]  stat_max_wait;
`endif

  dmem_arbiter #(
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MAX_WAIT),
    .CNT_WIDTH (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_ext_grants(stat_ext_grants),
    .stat_cpu_stalls(stat_cpu_stalls),
    .stat_max_wait  (stat_max_wait)
`endif
  );

  // Data memory: combinational read, write at the clock edge.
  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] shadow [64];
  logic [31:0] exp_q [$];
  int          model_cnt = 0;
  bit          rd_pend   = 1'b0;
  bit          obs_ready;
  bit          mem_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_ext(input bit valid, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.ext_valid = valid;
    bus.ext_we    = we;
    bus.ext_addr  = addr;
    bus.ext_wdata = wdata;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit         er;
    bit         eg;
    logic [5:0] a;
    @(negedge clk);
    er = !bus.cpu_req || (model_cnt == MAX_WAIT);
    eg = bus.ext_valid && er;
    obs_ready = bus.ext_ready;
    check("ext_ready", 32'(bus.ext_ready), 32'(er));
    check("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && eg));
    check("mem_we", 32'(bus.mem_we), 32'(eg ? bus.ext_we : (bus.cpu_req && bus.cpu_we)));
    check("mem_addr", bus.mem_addr, eg ? bus.ext_addr : bus.cpu_addr);
    check("mem_wdata", bus.mem_wdata, eg ? bus.ext_wdata : bus.cpu_wdata);
    a = eg ? bus.ext_addr[7:2] : bus.cpu_addr[7:2];
    if (mem_known) check("cpu_rdata", bus.cpu_rdata, shadow[a]);
    check("ext_rvalid", 32'(bus.ext_rvalid), 32'(rd_pend));
    if (rd_pend && exp_q.size() > 0) check("ext_rdata", bus.ext_rdata, exp_q.pop_front());
    if (eg && !bus.ext_we) exp_q.push_back(shadow[bus.ext_addr[7:2]]);
    @(posedge clk);
    if (eg && bus.ext_we) shadow[bus.ext_addr[7:2]] = bus.ext_wdata;
    else if (!eg && bus.cpu_req && bus.cpu_we) shadow[bus.cpu_addr[7:2]] = bus.cpu_wdata;
    if (reset) begin
      model_cnt = 0;
      rd_pend   = 1'b0;
      exp_q.delete();
    end else begin
      rd_pend = eg && !bus.ext_we;
      if (eg || !bus.ext_valid) model_cnt = 0;
      else if (model_cnt < MAX_WAIT) model_cnt = model_cnt + 1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
    check("rst_rdata", bus.ext_rdata, 32'd0);
    check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    reset = 1'b0;

    // Preload every word through the external port with the CPU idle.
    for (int i = 0; i < 64; i++) begin
      set_ext(1, 1, 32'(i) << 2, (i == 4) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5000000);
      cycle();
    end
    mem_known = 1'b1;

    // Idle CPU, external read of 0x10.
    set_ext(1, 0, 32'h10, 0);
    cycle();
    check("idle_read_ready", 32'(obs_ready), 32'd1);
    set_ext(0, 0, 0, 0);
    cycle();
    check("idle_read_data", bus.ext_rdata, 32'hDEADBEEF);

    // CPU busy every cycle, external read held: forced through on the MAX_WAIT-th cycle.
    set_cpu(1, 0, 32'h40, 0);
    set_ext(1, 0, 32'h80, 0);
    for (int i = 0; i <= int'(MAX_WAIT); i++) begin
      cycle();
      check("starve_ready", 32'(obs_ready), 32'(i == int'(MAX_WAIT)));
    end
    check("starve_cnt_clr", 32'(dut.wait_cnt), 32'd0);
    set_ext(0, 0, 0, 0);
    cycle();

    // CPU store with no external traffic.
    set_cpu(1, 1, 32'h20, 32'h55);
    cycle();
    check("cpu_store_mem", mem[8], 32'h55);

    // Forced external write collides with a CPU store to the same word.
    set_cpu(1, 1, 32'h20, 32'h55);
    set_ext(1, 1, 32'h20, 32'hAA);
    for (int i = 0; i <= int'(MAX_WAIT); i++) cycle();
    check("collide_ext_wins", mem[8], 32'hAA);
    set_ext(0, 0, 0, 0);
    cycle();
    check("collide_cpu_retry", mem[8], 32'h55);

    // External request drops after 2 blocked cycles, then reasserts.
    set_cpu(1, 0, 32'h44, 0);
    set_ext(1, 0, 32'h84, 0);
    cycle();
    cycle();
    set_ext(0, 0, 0, 0);
    cycle();
    check("drop_cnt_clr", 32'(dut.wait_cnt), 32'd0);
    set_ext(1, 0, 32'h84, 0);
    for (int i = 0; i <= int'(MAX_WAIT); i++) begin
      cycle();
      check("reassert_ready", 32'(obs_ready), 32'(i == int'(MAX_WAIT)));
    end
    set_ext(0, 0, 0, 0);
    set_cpu(0, 0, 0, 0);
    cycle();

    // Back-to-back external reads give back-to-back rvalid pulses.
    for (int i = 0; i < 3; i++) begin
      set_ext(1, 0, 32'(i + 10) << 2, 0);
      cycle();
    end
    set_ext(0, 0, 0, 0);
    cycle();
    cycle();

    // Reset in the cycle of an accepted external read drops the response.
    set_ext(1, 0, 32'h10, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_ext(0, 0, 0, 0);
    cycle();
    check("rst_mid_rvalid", 32'(bus.ext_rvalid), 32'd0);
    check("rst_mid_rdata", bus.ext_rdata, 32'd0);
    check("rst_mid_cnt", 32'(dut.wait_cnt), 32'd0);

    // Random traffic; external requests tend to be held until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!bus.ext_valid || obs_ready || ($urandom_range(0, 7) == 0)) begin
        set_ext(($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                32'($urandom_range(0, 63)) << 2, $urandom);
      end
      set_cpu(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              32'($urandom_range(0, 63)) << 2, $urandom);
      cycle();
    end
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
